sha256_msg_sched: RTL and testbench

- Produces the SHA-256 message-schedule words W0..W63 for one 512-bit block.
- Feeds the round datapath: the round logic consumes one Wt per accepted beat while the T1/T2 functions consume the working variables.
- Keeps a 16-word sliding window and computes Wt = sigma1(Wt-2) + Wt-7 + sigma0(Wt-15) + Wt-16 on the fly.
- Uses a valid/ready stream so the round engine can stall the schedule.

---
 rtl/sha256_msg_sched.sv | 107 ++++++++++
 tb/tb_sha256_msg_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams W0..W(NUM_ROUNDS-1) for one 512-bit block
// from a 16-word sliding window, one word per accepted valid/ready beat.
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic [31:0] window_reg  [16];
  logic [31:0] window_next [16];

  logic        load;
  logic        accept;
  logic        last_accept;
  logic [31:0] new_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign load        = (state_reg == IDLE) && start;
  assign accept      = (state_reg == RUN) && w_ready;
  assign last_accept = accept && (cnt_reg == LAST_IDX);

  // Window holds W(t)..W(t+15); the appended word is W(t+16).
  assign new_word = sigma1(window_reg[14]) + window_reg[9]
                  + sigma0(window_reg[1]) + window_reg[0];

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_shift
      assign window_next[gi] = load   ? block_in[511 - 32*gi -: 32] :
                               accept ? window_reg[gi + 1]          :
                                        window_reg[gi];
    end
  endgenerate

  assign window_next[15] = load   ? block_in[31:0] :
                           accept ? new_word       :
                                    window_reg[15];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (last_accept) begin
          // Counter parks on the final index rather than wrapping.
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (accept) begin
          cnt_next = cnt_reg + 6'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        window_reg[i] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      done_reg   <= done_next;
      window_reg <= window_next;
    end
  end

  assign busy    = (state_reg == RUN);
  assign w_valid = (state_reg == RUN);
  assign w_data  = window_reg[0];
  assign w_idx   = cnt_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: reference schedule pushed at start,
// popped and compared on every accepted beat; also a NUM_ROUNDS=16 instance.
module tb_sha256_msg_sched;

  localparam int NR = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [511:0] block_in;
  logic         busy, w_valid, w_ready, done;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;

  logic         s16_start;
  logic [511:0] s16_block;
  logic         s16_busy, s16_valid, s16_ready, s16_done;
  logic [31:0]  s16_data;
  logic [5:0]   s16_idx;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_data [$];
  logic [5:0]  exp_idx  [$];
  logic [31:0] obs [64];

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'h0, 32'h00000018};

  always #5 clk = ~clk;

  sha256_msg_sched #(.NUM_ROUNDS(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_idx(w_idx), .done(done)
  );

  sha256_msg_sched #(.NUM_ROUNDS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16_start), .block_in(s16_block),
    .busy(s16_busy), .w_valid(s16_valid), .w_ready(s16_ready),
    .w_data(s16_data), .w_idx(s16_idx), .done(s16_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vec_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, act, expv, $time);
    end else begin
      $display("ok   %s: %08h", tag, act);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Drives a new block and queues its full reference schedule.
  task automatic start_block(input logic [511:0] b);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ref_s1(w[t-2]) + w[t-7] + ref_s0(w[t-15]) + w[t-16];
    for (int t = 0; t < NR; t++) begin
      exp_data.push_back(w[t]);
      exp_idx.push_back(6'(t));
    end
    block_in = b;
    start    = 1'b1;
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    #1;
    start   = 1'b0;
    w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input bit rnd, input bit inject, input bit chain, input logic [511:0] nxt);
    bit last_acc, inj10, fin;
    int cyc;
    logic [31:0] ed;
    logic [5:0]  ei;
    last_acc = 0; inj10 = 0; fin = 0; cyc = 0;
    step(rnd);
    check("first_valid", 32'(w_valid), 32'd1);
    while (!fin && cyc < 600) begin
      cyc++;
      if (last_acc) begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("valid_after", 32'(w_valid), 32'd0);
        fin = 1;
        if (chain) start_block(nxt);
      end else begin
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
        if (w_valid && w_ready) begin
          if (exp_data.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            ed = exp_data.pop_front();
            ei = exp_idx.pop_front();
            check("w_data", w_data, ed);
            check("w_idx", 32'(w_idx), 32'(ei));
            obs[ei] = w_data;
            if (ei == 6'(NR - 1)) begin
              last_acc = 1;
              if (inject) begin
                start    = 1'b1;
                block_in = {16{32'hDEADBEEF}};
              end
            end
          end
        end
        if (inject && !inj10 && w_valid && w_idx == 6'd10) begin
          start    = 1'b1;
          block_in = {16{32'hDEADBEEF}};
          inj10    = 1;
        end
        step(rnd);
      end
    end
    if (!fin) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, beats, last_beat_cyc, done_cyc;
    logic [511:0] blk;

    rst_n = 1'b0; start = 1'b1; block_in = ABC_BLOCK; w_ready = 1'b1;
    s16_start = 1'b0; s16_block = '0; s16_ready = 1'b1;

    // Reset with start held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(w_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", w_data, 32'd0);
    check("rst_idx", 32'(w_idx), 32'd0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 32'(w_valid), 32'd0);
    @(negedge clk);
    check("post_rst_valid2", 32'(w_valid), 32'd0);

    // "abc" block, always ready
    start_block(ABC_BLOCK);
    drain(0, 0, 0, '0);
    check("abc_W0", obs[0], 32'h61626380);
    check("abc_W15", obs[15], 32'h00000018);
    check("abc_W16", obs[16], 32'h61626380);
    check("abc_W17", obs[17], 32'h000F0000);
    check("abc_W18", obs[18], 32'h7DA86405);
    check("abc_W19", obs[19], 32'h600003C6);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Random backpressure
    start_block(ABC_BLOCK);
    drain(1, 0, 0, '0);

    // Ignored starts mid-block and on final accept, then start on done cycle
    blk = rand_block();
    start_block(ABC_BLOCK);
    drain(0, 1, 1, blk);
    drain(1, 0, 0, '0);
    check("sb_empty", 32'(exp_data.size()), 32'd0);

    // Reset at w_idx = 30
    start_block(ABC_BLOCK);
    @(posedge clk); #1 start = 1'b0; w_ready = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (w_idx != 6'd30 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_idx30", 32'(w_idx), 32'd30);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(w_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", w_data, 32'd0);
    check("mid_rst_idx", 32'(w_idx), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    exp_data.delete();
    exp_idx.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_idle", 32'(w_valid), 32'd0);
    start_block('0);
    drain(0, 0, 0, '0);

    // NUM_ROUNDS = 16 instance
    blk = rand_block();
    s16_block = blk;
    s16_start = 1'b1;
    @(posedge clk); #1 s16_start = 1'b0; s16_block = '0;
    beats = 0; last_beat_cyc = -10; done_cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s16_valid && s16_ready) begin
        check("nr16_idx", 32'(s16_idx), 32'(beats));
        check("nr16_data", s16_data, blk[511 - 32*beats -: 32]);
        beats++;
        last_beat_cyc = c;
      end
      if (s16_done && done_cyc < 0) done_cyc = c;
    end
    check("nr16_beats", 32'(beats), 32'd16);
    check("nr16_done_lat", 32'(done_cyc - last_beat_cyc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
